// File: rtl/sync_fifo_flex_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared definitions for sync_fifo_flex:
//   - ptr_width()    : pointer/count width for a given address width
//   - MODE_STD/FWFT  : read-mode selector values for the FWFT parameter
//   - fifo_flags_t   : the four occupancy flags
//   - decode_flags() : occupancy count -> flags
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int MODE_STD  = 0;
    localparam int MODE_FWFT = 1;

    // One extra bit so that a completely full FIFO (count == DEPTH) is
    // representable and so that the pointers can tell full from empty.
    function automatic int ptr_width(input int addrwidth);
        return addrwidth + 1;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic fifo_flags_t decode_flags(input int count,
                                                 input int depth,
                                                 input int af_level,
                                                 input int ae_level);
        fifo_flags_t f;
        f.full         = (count == depth);
        f.empty        = (count == 0);
        f.almost_full  = (count >= af_level);
        f.almost_empty = (count <= ae_level);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_flex_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex_if
// Bus bundle between a FIFO user (master) and sync_fifo_flex (slave).
//   I_data_in, I_wren, I_rden        : write data / write request / read request
//   O_data_out, O_valid              : read data and its qualifier
//   full, empty, almost_full,
//   almost_empty, O_count            : occupancy status
// Optional (macro SYNC_FIFO_ERR_FLAGS_EN):
//   I_clr_err, O_overflow, O_underflow : sticky error flags and their clear
//
// Handshake: a write is accepted on a rising clk edge when I_wren=1 and
// full=0; a read is accepted when I_rden=1 and empty=0. Requests made while
// full/empty are dropped without side effects. O_valid qualifies O_data_out:
// in standard mode it pulses for one cycle after each accepted read, in FWFT
// mode it is simply !empty and the head word is presented on O_data_out.
// -----------------------------------------------------------------------------
interface sync_fifo_flex_if #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5
);
    logic [DATAWIDTH-1:0] I_data_in;
    logic                 I_wren;
    logic                 I_rden;
    logic [DATAWIDTH-1:0] O_data_out;
    logic                 O_valid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [ADDRWIDTH:0]   O_count;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic                 I_clr_err;
    logic                 O_overflow;
    logic                 O_underflow;
`endif

    modport master (
        output I_data_in, I_wren, I_rden,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        output I_clr_err,
        input  O_overflow, O_underflow,
`endif
        input  O_data_out, O_valid, full, empty, almost_full, almost_empty, O_count
    );

    modport slave (
        input  I_data_in, I_wren, I_rden,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        input  I_clr_err,
        output O_overflow, O_underflow,
`endif
        output O_data_out, O_valid, full, empty, almost_full, almost_empty, O_count
    );

endinterface

// File: rtl/sync_fifo_flex_mem_sdp.sv
// -----------------------------------------------------------------------------
// fifo_mem_sdp
// Simple dual-port register array: one synchronous write port, one
// asynchronous (combinational) read port. Contents are never reset.
//   i_clk   : write clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// -----------------------------------------------------------------------------
module fifo_mem_sdp #(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_we,
    input  logic [ADDRWIDTH-1:0] i_waddr,
    input  logic [DATAWIDTH-1:0] i_wdata,
    input  logic [ADDRWIDTH-1:0] i_raddr,
    output logic [DATAWIDTH-1:0] o_rdata
);
    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [DATAWIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// sync_fifo_flex
// Single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds and a selectable standard (registered) or first-word-fall-
// through read mode.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : sync_fifo_flex_if.slave (data, requests, output, status flags)
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow /
// underflow flags with a clear input.
// -----------------------------------------------------------------------------
module sync_fifo_flex
    import fifo_pkg::*;
#(
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 5,
    parameter int AF_LEVEL  = 28,
    parameter int AE_LEVEL  = 4,
    parameter int FWFT      = 0
) (
    input  logic             clk,
    input  logic             rst,
    sync_fifo_flex_if.slave  bus
);
    localparam int PW    = ptr_width(ADDRWIDTH);
    localparam int DEPTH = 1 << ADDRWIDTH;

    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [PW-1:0]        r_count;
    fifo_flags_t          w_flags;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [DATAWIDTH-1:0] w_rd_data;

    // All flags come from the registered count, so they move exactly one
    // cycle after the edge that accepted the write/read.
    assign w_flags  = decode_flags(int'(r_count), DEPTH, AF_LEVEL, AE_LEVEL);
    assign w_wr_acc = bus.I_wren & ~w_flags.full;
    assign w_rd_acc = bus.I_rden & ~w_flags.empty;

    fifo_mem_sdp #(
        .DATAWIDTH (DATAWIDTH),
        .ADDRWIDTH (ADDRWIDTH)
    ) u_mem (
        .i_clk   (clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr[ADDRWIDTH-1:0]),
        .i_wdata (bus.I_data_in),
        .i_raddr (r_rd_ptr[ADDRWIDTH-1:0]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + PW'(w_wr_acc) - PW'(w_rd_acc);
        end
    end

    // The pointer distance and the separately kept count must never disagree.
    a_count_matches_ptrs : assert property (@(posedge clk) disable iff (rst)
        r_count == PW'(r_wr_ptr - r_rd_ptr));

    assign bus.full         = w_flags.full;
    assign bus.empty        = w_flags.empty;
    assign bus.almost_full  = w_flags.almost_full;
    assign bus.almost_empty = w_flags.almost_empty;
    assign bus.O_count      = r_count;

    generate
        if (FWFT == MODE_FWFT) begin : g_fwft
            // Head word is presented directly. It is forced to zero while
            // empty so the output is defined after reset even though the
            // array itself is never cleared.
            assign bus.O_valid    = ~w_flags.empty;
            assign bus.O_data_out = w_flags.empty ? '0 : w_rd_data;
        end else begin : g_std
            logic [DATAWIDTH-1:0] r_data;
            logic                 r_valid;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else begin
                    r_valid <= w_rd_acc;
                    if (w_rd_acc) r_data <= w_rd_data;
                end
            end

            assign bus.O_valid    = r_valid;
            assign bus.O_data_out = r_data;
        end
    endgenerate

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    // Sticky; a new error in the same cycle as a clear wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.I_wren & w_flags.full)       r_overflow <= 1'b1;
            else if (bus.I_clr_err)              r_overflow <= 1'b0;
            if (bus.I_rden & w_flags.empty)      r_underflow <= 1'b1;
            else if (bus.I_clr_err)              r_underflow <= 1'b0;
        end
    end

    assign bus.O_overflow  = r_overflow;
    assign bus.O_underflow = r_underflow;
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo_flex
// Drives one standard-mode and one FWFT-mode sync_fifo_flex with identical
// stimulus. A queue-based reference model tracks the FIFO contents; the
// standard-mode read results go into an expected queue that a negedge
// monitor pops whenever O_valid is seen.
// -----------------------------------------------------------------------------
module tb_sync_fifo_flex;
  localparam int DW    = 8;
  localparam int AW    = 5;
  localparam int DEPTH = 32;
  localparam int AF    = 28;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          wren = 1'b0;
  logic          rden = 1'b0;
  logic          clr_err = 1'b0;

  // reference model
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] exp_q[$];
  logic          exp_valid = 1'b0;
  logic          model_ovf = 1'b0;
  logic          model_unf = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_fifo_flex_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) if_std ();
  sync_fifo_flex_if #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) if_fwft ();

  assign if_std.I_data_in  = din;
  assign if_std.I_wren     = wren;
  assign if_std.I_rden     = rden;
  assign if_fwft.I_data_in = din;
  assign if_fwft.I_wren    = wren;
  assign if_fwft.I_rden    = rden;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  assign if_std.I_clr_err  = clr_err;
  assign if_fwft.I_clr_err = clr_err;
`endif

  sync_fifo_flex #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) u_std (
    .clk (clk),
    .rst (rst),
    .bus (if_std.slave)
  );

  sync_fifo_flex #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (if_fwft.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // status of both DUTs against the model occupancy
  task automatic check_status();
    int n;
    n = model_q.size();
    chk("std_count", 32'(if_std.O_count), n);
    chk("std_full",  32'(if_std.full), 32'(n == DEPTH));
    chk("std_empty", 32'(if_std.empty), 32'(n == 0));
    chk("std_af",    32'(if_std.almost_full), 32'(n >= AF));
    chk("std_ae",    32'(if_std.almost_empty), 32'(n <= AE));
    chk("fwft_count", 32'(if_fwft.O_count), n);
    chk("fwft_full",  32'(if_fwft.full), 32'(n == DEPTH));
    chk("fwft_empty", 32'(if_fwft.empty), 32'(n == 0));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    chk("std_ovf",  32'(if_std.O_overflow), 32'(model_ovf));
    chk("std_unf",  32'(if_std.O_underflow), 32'(model_unf));
    chk("fwft_ovf", 32'(if_fwft.O_overflow), 32'(model_ovf));
    chk("fwft_unf", 32'(if_fwft.O_underflow), 32'(model_unf));
`endif
  endtask

  // one clock of stimulus; called at posedge+1, returns at posedge+1
  task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d, input logic clr);
    bit wa, ra, ovf_set, unf_set;
    wren = wr; rden = rd; din = d; clr_err = clr;
    wa      = wr && (model_q.size() < DEPTH);
    ra      = rd && (model_q.size() > 0);
    ovf_set = wr && (model_q.size() == DEPTH);
    unf_set = rd && (model_q.size() == 0);
    @(posedge clk);
    #1;
    if (ra) exp_q.push_back(model_q.pop_front());
    if (wa) model_q.push_back(d);
    exp_valid = ra;
    if (ovf_set) model_ovf = 1'b1; else if (clr) model_ovf = 1'b0;
    if (unf_set) model_unf = 1'b1; else if (clr) model_unf = 1'b0;
    wren = 1'b0; rden = 1'b0; clr_err = 1'b0;
    check_status();
  endtask

  // monitor: standard-mode output against expected queue, FWFT head against model
  always @(negedge clk) begin
    if (!rst) begin
      chk("std_valid", 32'(if_std.O_valid), 32'(exp_valid));
      if (if_std.O_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL std_spurious: O_valid with data %0h but nothing expected at %0t", if_std.O_data_out, $time);
        end else begin
          chk("std_data", 32'(if_std.O_data_out), 32'(exp_q.pop_front()));
        end
      end
      chk("fwft_valid", 32'(if_fwft.O_valid), 32'(model_q.size() != 0));
      if (model_q.size() != 0) chk("fwft_data", 32'(if_fwft.O_data_out), 32'(model_q[0]));
    end
  end

  task automatic random_phase(input int cycles, input int p_wr, input int p_rd);
    for (int i = 0; i < cycles; i++)
      step($urandom_range(0, 99) < p_wr, $urandom_range(0, 99) < p_rd,
           DW'($urandom_range(0, 255)), $urandom_range(0, 15) == 0);
  endtask

  initial begin
    logic [DW-1:0] inc;

    // reset state
    #3;
    chk("rst_count", 32'(if_std.O_count), 0);
    chk("rst_empty", 32'(if_std.empty), 1);
    chk("rst_full",  32'(if_std.full), 0);
    chk("rst_ae",    32'(if_std.almost_empty), 1);
    chk("rst_af",    32'(if_std.almost_full), 0);
    chk("rst_valid", 32'(if_std.O_valid), 0);
    chk("rst_data",  32'(if_std.O_data_out), 0);
    chk("rst_fwft_valid", 32'(if_fwft.O_valid), 0);
    chk("rst_fwft_data",  32'(if_fwft.O_data_out), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // fill 0x00..0x1F, then a dropped write while full
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i), 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("full_drop_count", 32'(if_std.O_count), DEPTH);

    // drain everything plus one ignored read
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // steady state at count 10 with simultaneous read/write, pointers wrap
    inc = 8'h40;
    for (int i = 0; i < 10; i++) begin step(1'b1, 1'b0, inc, 1'b0); inc++; end
    for (int i = 0; i < 50; i++) begin step(1'b1, 1'b1, inc, 1'b0); inc++; end
    chk("steady_count", 32'(if_std.O_count), 10);

    // FWFT single-word fall-through
    while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h7E, 1'b0);
    chk("fwft_first_valid", 32'(if_fwft.O_valid), 1);
    chk("fwft_first_data",  32'(if_fwft.O_data_out), 32'h7E);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("fwft_pop_valid", 32'(if_fwft.O_valid), 0);

    // randomized traffic: fill-biased, drain-biased, balanced
    random_phase(600, 80, 30);
    random_phase(600, 30, 80);
    random_phase(800, 50, 50);

    // asynchronous reset mid-burst at count 17
    while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b1, 1'b0, DW'($urandom_range(0, 255)), 1'b0);
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("pre_rst_count", 32'(if_std.O_count), 17);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(if_std.O_count), 0);
    chk("async_rst_empty", 32'(if_std.empty), 1);
    chk("async_rst_valid", 32'(if_std.O_valid), 0);
    chk("async_rst_fwft_valid", 32'(if_fwft.O_valid), 0);
    chk("async_rst_fwft_count", 32'(if_fwft.O_count), 0);
    model_q.delete();
    exp_q.delete();
    exp_valid = 1'b0;
    model_ovf = 1'b0;
    model_unf = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check_status();

    // more traffic after reset, including error-flag corners
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    random_phase(500, 70, 40);
    while (model_q.size() < DEPTH) step(1'b1, 1'b0, DW'($urandom_range(0, 255)), 1'b0);
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    while (model_q.size() > 0) step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    chk("exp_q_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flex.md
Name: sync_fifo_flex

Overview:
Single-clock, parametrised successor to the dual-clock FIFO, for buffering within one clock domain (e.g. between pipeline stages).
- Generalised data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, and a selectable standard or first-word-fall-through (FWFT) read mode.
- No clock-domain crossing logic: binary pointers only.

Parameters:
DATAWIDTH, 8, data word width in bits (>=1)
ADDRWIDTH, 5, log2 of depth; DEPTH = 2**ADDRWIDTH (>=2)
AF_LEVEL, 28, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
rst  input  1  asynchronous active-high reset
I_data_in  input  DATAWIDTH  write data
I_wren  input  1  write request
I_rden  input  1  read request (pop in FWFT mode)
O_data_out  output  DATAWIDTH  read data
O_valid  output  1  O_data_out qualifier
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
O_count  output  ADDRWIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high. Reset asserts immediately and releases on a `clk` edge.
- Reset state:
  - Pointers and count = 0.
  - Outputs: empty=1, full=0, almost_empty=1, almost_full=0, O_valid=0, O_data_out=0.
  - Memory contents are not reset.
- Pointers: wr_ptr and rd_ptr are ADDRWIDTH+1 bits. The MSB differs on wrap. Index = low ADDRWIDTH bits. Wrap from DEPTH-1 to 0 is natural overflow.
- Accept rules:
  - wr_acc = I_wren & !full.
  - rd_acc = I_rden & !empty.
  - Write while full is dropped; memory and pointers are unchanged.
  - Read while empty is ignored.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
  - When full: the write is dropped and the read is accepted.
  - When empty: the read is ignored and the write is accepted.
- Count update: count <= count + wr_acc - rd_acc, registered.
  - All flags decode combinationally from the registered count, so they change exactly one cycle after the accepting edge.
- Standard mode (FWFT=0):
  - On rd_acc, O_data_out <= mem[rd_idx] at that edge; O_valid is high for the following cycle only.
  - O_data_out otherwise holds its last value.
  - Read latency: 1 clock.
- FWFT mode (FWFT=1):
  - O_data_out = mem[rd_idx] (combinational read of head).
  - O_valid = !empty.
  - I_rden with O_valid pops the head; the next word is visible in the following cycle.
  - A write to an empty FIFO makes O_valid rise 1 cycle after the write edge.
- Write-through: a read of the same slot in the cycle it is written never occurs, because empty blocks the read.
- Reset mid-operation: all state returns to the reset values immediately; data in flight is discarded.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- Defined: adds ports I_clr_err (input, 1), O_overflow (output, 1) and O_underflow (output, 1).
  - O_overflow sets on the cycle after I_wren & full.
  - O_underflow sets on the cycle after I_rden & empty.
  - Both are sticky until I_clr_err=1 at a clock edge or rst. Set has priority over clear in the same cycle.
- Undefined: these ports and their logic are absent; drops and ignores remain silent.

Decomposition:
- Package fifo_pkg holds:
  - localparam function for pointer width (ADDRWIDTH+1);
  - FWFT mode constants MODE_STD=0 and MODE_FWFT=1;
  - a shared count-to-flag decode function.
- One sub-module, fifo_mem_sdp: simple dual-port register array with parameters DATAWIDTH and ADDRWIDTH.
  - Synchronous write port.
  - Asynchronous read port, registered by the parent in standard mode.
- Control logic (pointers, count, flags, output register) stays in sync_fifo_flex.

Test Plan:
- Reset then 32 writes of 8'h00..8'h1F, no reads -> count goes 0..32; almost_full rises after write 28; full rises after write 32; 33rd write (8'hAA) dropped, count stays 32.
- From full, 32 reads (FWFT=0) -> O_data_out 8'h00..8'h1F, each 1 cycle after its rd_acc with O_valid pulses; almost_empty rises at count 4; empty at 0; extra read leaves O_valid=0.
- Continuous simultaneous wren+rden at count 10 for 50 cycles with incrementing data -> count stays 10; pointers wrap past 31 with output order preserved.
- FWFT=1: single write 8'h7E to empty -> O_valid=1 and O_data_out=8'h7E one cycle later; rden -> O_valid=0 next cycle.
- Assert rst asynchronously mid-burst at count 17 -> empty=1, count=0, O_valid=0 immediately, before the next edge.
- SYNC_FIFO_ERR_FLAGS_EN: write when full -> O_overflow=1 next cycle, held until I_clr_err; read when empty -> O_underflow=1.
